// File: rtl/efb_wb_arbiter_pkg.sv
// Shared definitions for the EFB Wishbone arbiter: FSM encodings, EFB timer
// register addresses, requester indices and small lane/one-hot helpers.
package efb_wb_arbiter_pkg;

    // Arbiter FSM encodings; GAP is the mandatory idle cycle between EFB cycles.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // EFB timer/counter register addresses used by the typical requesters.
    localparam logic [7:0] TCCNT0 = 8'h65;
    localparam logic [7:0] TCCNT1 = 8'h66;

    // Requester indices: bit 0 is the LED-refresh poll, bit 1 the UART path.
    localparam int   NUM_REQ  = 2;
    localparam logic REQ_LED  = 1'b0;
    localparam logic REQ_UART = 1'b1;

    // Request patterns that matter to the arbitration decision.
    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_BOTH = 2'b11;

    // Extract requester idx's byte from a packed {req1, req0} 16-bit bus.
    function automatic logic [7:0] byte_lane(input logic [15:0] v, input logic idx);
        return idx ? v[15:8] : v[7:0];
    endfunction

    // One-hot done pattern for requester idx.
    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/efb_wb_arbiter_if.sv
// Bundle of requester-side and Wishbone-side signals of the EFB arbiter.
// Names follow the arbiter's port list so waveforms read the same either way.
//
// Requester handshake: a requester raises its i_Req bit (level) together with
// its We/Addr/Wdata lane and holds it until its o_Done bit pulses for one
// cycle; it must drop i_Req in the cycle after o_Done, otherwise the level
// seen in IDLE is treated as a fresh request. o_Err qualifies o_Done (timeout),
// o_Rdata is valid in the o_Done cycle and held until the next o_Done.
interface efb_wb_arbiter_if;
    logic [1:0]  i_Req;
    logic [1:0]  i_We;
    logic [15:0] i_Addr;
    logic [15:0] i_Wdata;
    logic [1:0]  o_Done;
    logic        o_Err;
    logic [7:0]  o_Rdata;
    logic        o_Busy;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [7:0]  o_wb_adr;
    logic [7:0]  o_wb_dat;
    logic [7:0]  i_wb_dat;
    logic        i_wb_ack;

    // Arbiter side: it is the Wishbone master towards the EFB.
    modport master (
        input  i_Req, i_We, i_Addr, i_Wdata, i_wb_dat, i_wb_ack,
        output o_Done, o_Err, o_Rdata, o_Busy,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat
    );

    // Environment side: requesters plus the EFB slave.
    modport slave (
        output i_Req, i_We, i_Addr, i_Wdata, i_wb_dat, i_wb_ack,
        input  o_Done, o_Err, o_Rdata, o_Busy,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat
    );
endinterface

// File: rtl/efb_wb_arbiter.sv
// Two-requester round-robin arbiter in front of the EFB Wishbone slave port.
// Runs one 8-bit classic cycle at a time, aborts after TIMEOUT_CYCLES without
// ack, and always leaves one idle cycle between EFB cycles.
module efb_wb_arbiter
    import efb_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64   // legal range 2..255
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    efb_wb_arbiter_if.master  bus,
    output state_t            o_dbg_state
);

    // Counter value of the last BUS cycle before the transfer is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        gnt, gnt_n;            // requester owning the current cycle
    logic        last_ptr, last_ptr_n;  // last granted requester
    logic [7:0]  cnt, cnt_n;            // cycles spent in BUS
    logic        cyc, cyc_n;
    logic        we, we_n;
    logic [7:0]  adr, adr_n;
    logic [7:0]  dat, dat_n;
    logic [7:0]  rdata, rdata_n;
    logic [1:0]  done, done_n;
    logic        err, err_n;
    logic        pick;

    // Round robin: a lone requester wins; on a tie the one not granted last wins.
    assign pick = (bus.i_Req == REQ_BOTH) ? ~last_ptr : bus.i_Req[REQ_UART];

    // Next-state and next-output decode; everything holds unless changed below.
    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        last_ptr_n = last_ptr;
        cnt_n      = cnt;
        cyc_n      = cyc;
        we_n       = we;
        adr_n      = adr;
        dat_n      = dat;
        rdata_n    = rdata;
        done_n     = 2'b00;
        err_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.i_Req != REQ_NONE) begin
                    gnt_n      = pick;
                    last_ptr_n = pick;
                    we_n       = bus.i_We[pick];
                    adr_n      = byte_lane(bus.i_Addr, pick);
                    dat_n      = byte_lane(bus.i_Wdata, pick);
                    cyc_n      = 1'b1;
                    state_n    = ST_BUS;
                end
            end

            ST_BUS: begin
                // Ack wins over timeout, so an ack in the final cycle succeeds.
                if (bus.i_wb_ack) begin
                    cyc_n  = 1'b0;
                    done_n = onehot(gnt);
                    if (!we) begin
                        rdata_n = bus.i_wb_dat;
                    end
                    state_n = ST_GAP;
                end else if (cnt == TIMEOUT_LAST) begin
                    cyc_n   = 1'b0;
                    done_n  = onehot(gnt);
                    err_n   = 1'b1;
                    state_n = ST_GAP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            ST_GAP: begin
                // One cycle with cyc/stb low; requests are not looked at here.
                cnt_n   = 8'd0;
                state_n = ST_IDLE;
            end

            default: begin
                cyc_n   = 1'b0;
                cnt_n   = 8'd0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bus, pointer, counter and result registers; reset drops cyc at once.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            gnt      <= REQ_LED;
            last_ptr <= REQ_UART;   // so requester 0 wins the first tie
            cnt      <= 8'd0;
            cyc      <= 1'b0;
            we       <= 1'b0;
            adr      <= 8'd0;
            dat      <= 8'd0;
            rdata    <= 8'd0;
            done     <= 2'b00;
            err      <= 1'b0;
        end else begin
            gnt      <= gnt_n;
            last_ptr <= last_ptr_n;
            cnt      <= cnt_n;
            cyc      <= cyc_n;
            we       <= we_n;
            adr      <= adr_n;
            dat      <= dat_n;
            rdata    <= rdata_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    assign bus.o_wb_cyc = cyc;
    assign bus.o_wb_stb = cyc;
    assign bus.o_wb_we  = we;
    assign bus.o_wb_adr = adr;
    assign bus.o_wb_dat = dat;
    assign bus.o_Done   = done;
    assign bus.o_Err    = err;
    assign bus.o_Rdata  = rdata;
    assign bus.o_Busy   = (state != ST_IDLE);
    assign o_dbg_state  = state;

endmodule
